nand_stim_seq: RTL

Stimulus sequencer for the four-input NAND gate stage; drives its `a`, `b`, `c`, `d` inputs.
- Steps through all 16 input combinations, either manually from a debounced push-button or automatically at a fixed cycle interval.
- Reports the current vector index, a valid flag and an end-of-sweep pulse, so the board LEDs or a bench checker can line up the NAND outputs with the applied vector.

---
 rtl/nand_stim_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/nand_stim_seq.sv
// Stimulus sequencer for a four-input NAND stage: walks all 16 {a,b,c,d} codes by button or timer.
// Optional build macro NAND_STIM_GRAY_EN selects Gray-coded stimulus instead of plain binary.
module nand_stim_seq #(
   parameter int DEBOUNCE_CYC = 16,
   parameter int AUTO_DIV     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_step,
   input  logic       auto_en,
   input  logic       hold,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic [3:0] vec_idx,
   output logic       vec_valid,
   output logic       sweep_done
);

   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int TW = $clog2(AUTO_DIV);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] T_LAST  = TW'(AUTO_DIV - 1);

   typedef enum logic [1:0] {IDLE, MAN, AUTO, DONE} state_t;

   function automatic logic [3:0] to_code(input logic [3:0] idx);
`ifdef NAND_STIM_GRAY_EN
      return idx ^ (idx >> 1);
`else
      return idx;
`endif
   endfunction

   logic          sync1_reg, sync2_reg;
   logic          db_level_reg;
   logic [DW-1:0] db_cnt_reg;
   logic          step_reg;

   // The step pulse is registered so the FSM never sees a combinational path from the debouncer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg    <= 1'b0;
         sync2_reg    <= 1'b0;
         db_level_reg <= 1'b0;
         db_cnt_reg   <= '0;
         step_reg     <= 1'b0;
      end else begin
         sync1_reg <= btn_step;
         sync2_reg <= sync1_reg;
         step_reg  <= 1'b0;
         if (sync2_reg == db_level_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg >= DB_LAST) begin
            db_level_reg <= sync2_reg;
            db_cnt_reg   <= '0;
            step_reg     <= sync2_reg;
         end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
         end
      end
   end

   state_t        state_reg, state_next;
   logic [3:0]    idx_reg, idx_next;
   logic          valid_reg, valid_next;
   logic          done_reg, done_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic [3:0]    code_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= 4'd0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
         timer_reg <= '0;
         code_reg  <= 4'd0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         valid_reg <= valid_next;
         done_reg  <= done_next;
         timer_reg <= timer_next;
         code_reg  <= to_code(idx_next);
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      valid_next = valid_reg;
      done_next  = 1'b0;
      timer_next = timer_reg;
      case (state_reg)
         IDLE: begin
            idx_next   = 4'd0;
            valid_next = 1'b0;
            if (auto_en) begin
               state_next = AUTO;
               valid_next = 1'b1;
               timer_next = '0;
            end else if (step_reg) begin
               state_next = MAN;
               valid_next = 1'b1;
            end
         end
         MAN: begin
            if (auto_en) begin
               state_next = AUTO;
               timer_next = '0;
            end else if (step_reg) begin
               idx_next  = idx_reg + 4'd1;
               done_next = (idx_reg == 4'd15);
            end
         end
         AUTO: begin
            // Leaving auto mode wins over a coincident timer terminal: no increment.
            if (!auto_en) begin
               state_next = MAN;
            end else if (!hold) begin
               if (timer_reg >= T_LAST) begin
                  timer_next = '0;
                  if (idx_reg == 4'd15) begin
                     state_next = DONE;
                     done_next  = 1'b1;
                  end else begin
                     idx_next = idx_reg + 4'd1;
                  end
               end else begin
                  timer_next = timer_reg + 1'b1;
               end
            end
         end
         DONE: begin
            if (!auto_en) begin
               state_next = IDLE;
               idx_next   = 4'd0;
               valid_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign {a, b, c, d} = code_reg;
   assign vec_idx      = idx_reg;
   assign vec_valid    = valid_reg;
   assign sweep_done   = done_reg;

endmodule
